// File: rtl/shift_seq_pkg.sv
// Shared constants, operation/state encodings and the strobe decoder for the
// shift-register command sequencer.
package shift_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SHL   = 2'b10,
        OP_SHR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        INIT = 2'b00,
        IDLE = 2'b01,
        EXEC = 2'b10,
        DONE = 2'b11
    } state_e;

    // Strobe vector ordered {shiftRight, shiftLeft, loade, clear}; always one-hot.
    function automatic logic [3:0] op_strobes(input op_e op);
        logic [3:0] sel;
        case (op)
            OP_CLEAR: sel = 4'b0001;
            OP_LOAD:  sel = 4'b0010;
            OP_SHL:   sel = 4'b0100;
            OP_SHR:   sel = 4'b1000;
            default:  sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/shift_register_sequencer_if.sv
// Command channel plus downstream register drive of the sequencer.
interface shift_register_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmdValid;
    logic             cmdReady;
    logic [1:0]       cmdOp;
    logic [WIDTH-1:0] cmdData;
    logic [CNT_W-1:0] cmdCount;
    logic             clear;
    logic             loade;
    logic             shiftLeft;
    logic             shiftRight;
    logic [WIDTH-1:0] D;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output cmdValid, cmdOp, cmdData, cmdCount,
        input  cmdReady, clear, loade, shiftLeft, shiftRight, D, done, result, busy
    );

    modport slave (
        input  cmdValid, cmdOp, cmdData, cmdCount,
        output cmdReady, clear, loade, shiftLeft, shiftRight, D, done, result, busy
    );
endinterface

// File: rtl/shift_step_counter.sv
// Loadable down-counter of remaining shift steps; zero_o is registered so it
// can be used directly as the EXEC exit condition.
module shift_step_counter
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic             zero_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else if (load_i) begin
            count_q <= load_val_i;
            zero_q  <= (load_val_i == '0);
        end else if (dec_i && !zero_q) begin
            count_q <= count_q - CNT_W'(1);
            zero_q  <= (count_q == CNT_W'(1));
        end else begin
            count_q <= count_q;
            zero_q  <= zero_q;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/shift_register_sequencer.sv
// Expands clear/load/shift commands into one-hot strobes for a downstream
// shift register and tracks its contents in a shadow copy.
module shift_register_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                       clock,
    input  logic                       resetN,
    shift_register_sequencer_if.slave  bus
);

    state_e           state_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             clear_q;
    logic             loade_q;
    logic             shl_q;
    logic             shr_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;

    op_e              cmd_op_s;
    logic             accept_s;
    logic             zero_shift_s;
    logic [3:0]       accept_strobes_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;

    // Command decode; the counter holds steps remaining after the current one.
    always_comb begin
        cmd_op_s         = op_e'(bus.cmdOp);
        accept_s         = (state_q == IDLE) && ready_q && bus.cmdValid;
        zero_shift_s     = ((cmd_op_s == OP_SHL) || (cmd_op_s == OP_SHR)) && (bus.cmdCount == '0);
        accept_strobes_s = 4'b0000;
        cnt_load_val_s   = '0;
        if (zero_shift_s) begin
            accept_strobes_s = 4'b0000;
        end else begin
            accept_strobes_s = op_strobes(cmd_op_s);
        end
        if ((cmd_op_s == OP_SHL) || (cmd_op_s == OP_SHR)) begin
            cnt_load_val_s = zero_shift_s ? '0 : (bus.cmdCount - CNT_W'(1));
        end else begin
            cnt_load_val_s = '0;
        end
        cnt_dec_s = (state_q == EXEC);
    end

    // Shadow follows the strobe the downstream register samples this edge.
    always_comb begin
        shadow_d = shadow_q;
        if (clear_q) begin
            shadow_d = '0;
        end else if (loade_q) begin
            shadow_d = d_q;
        end else if (shl_q) begin
            shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
        end else if (shr_q) begin
            shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
        end else begin
            shadow_d = shadow_q;
        end
    end

    shift_step_counter #(.CNT_W(CNT_W)) u_step_counter (
        .clk        (clock),
        .rst_n      (resetN),
        .load_i     (accept_s),
        .dec_i      (cnt_dec_s),
        .load_val_i (cnt_load_val_s),
        .zero_o     (cnt_zero_s)
    );

    // Shadow register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    // Sequencer FSM; the INIT clear resynchronises the unreset downstream register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= INIT;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            {shr_q, shl_q, loade_q, clear_q} <= 4'b0000;
            d_q      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    {shr_q, shl_q, loade_q, clear_q} <= 4'b0001;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept_s) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        {shr_q, shl_q, loade_q, clear_q} <= accept_strobes_s;
                        if (cmd_op_s == OP_LOAD) begin
                            d_q <= bus.cmdData;
                        end else begin
                            d_q <= d_q;
                        end
                        if (zero_shift_s) begin
                            done_q   <= 1'b1;
                            result_q <= shadow_q;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= EXEC;
                        end
                    end else begin
                        {shr_q, shl_q, loade_q, clear_q} <= 4'b0000;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_zero_s) begin
                        {shr_q, shl_q, loade_q, clear_q} <= 4'b0000;
                        done_q   <= 1'b1;
                        result_q <= shadow_d;
                        state_q  <= DONE;
                    end else begin
                        state_q  <= EXEC;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    {shr_q, shl_q, loade_q, clear_q} <= 4'b0000;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign bus.cmdReady   = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.clear      = clear_q;
    assign bus.loade      = loade_q;
    assign bus.shiftLeft  = shl_q;
    assign bus.shiftRight = shr_q;
    assign bus.D          = d_q;
    assign bus.result     = result_q;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Directed bench for shift_register_sequencer with a behavioural downstream
// 4-bit shift register whose Q is compared against result on every done.
module tb_shift_register_sequencer;
    import shift_seq_pkg::*;

    logic       clk;
    logic       resetN;
    logic [3:0] q_ds;
    logic [4:0] obs_s;
    int         n_checks = 0;
    int         n_pass   = 0;

    shift_register_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

    shift_register_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clock  (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs_s = {bus.done, bus.shiftRight, bus.shiftLeft, bus.loade, bus.clear};

    // Downstream register: no reset, clear > load > left > right.
    always @(posedge clk) begin
        if (bus.clear)           q_ds <= 4'b0000;
        else if (bus.loade)      q_ds <= bus.D;
        else if (bus.shiftLeft)  q_ds <= {q_ds[2:0], 1'b0};
        else if (bus.shiftRight) q_ds <= {1'b0, q_ds[3:1]};
        else                     q_ds <= q_ds;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (resetN) begin
            check_eq("onehot", 32'($countones(obs_s[3:0]) <= 1), 32'd1);
            if (bus.done) check_eq("q_vs_result", q_ds, bus.result);
        end
    end

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!bus.cmdReady && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_ready"}, bus.cmdReady, 1'b1);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                           input logic [2:0] cnt, input int n, input logic [3:0] exp_res);
        logic [3:0] sel;
        sel = 4'b0001 << op;
        wait_ready(tag);
        bus.cmdValid = 1'b1;
        bus.cmdOp    = op;
        bus.cmdData  = data;
        bus.cmdCount = cnt;
        @(negedge clk);
        bus.cmdValid = 1'b0;
        for (int k = 0; k < n; k++) begin
            check_eq({tag, "_strobe"}, obs_s, {1'b0, sel});
            check_eq({tag, "_busy_ready"}, {bus.busy, bus.cmdReady}, 2'b10);
            if (op == OP_LOAD) check_eq({tag, "_D"}, bus.D, data);
            @(negedge clk);
        end
        check_eq({tag, "_done"}, obs_s, 5'b10000);
        check_eq({tag, "_result"}, bus.result, exp_res);
        @(negedge clk);
        check_eq({tag, "_after"}, {bus.cmdReady, bus.done}, 2'b10);
    endtask

    initial begin
        resetN       = 1'b0;
        bus.cmdValid = 1'b0;
        bus.cmdOp    = 2'b00;
        bus.cmdData  = 4'b0000;
        bus.cmdCount = 3'd0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_outputs", {obs_s, bus.cmdReady, bus.busy}, 7'b0);
        check_eq("rst_data", {bus.D, bus.result}, 8'h00);
        resetN = 1'b1;
        @(negedge clk);
        check_eq("init_clear", obs_s, 5'b00001);
        check_eq("init_ready_busy", {bus.cmdReady, bus.busy}, 2'b00);
        @(negedge clk);
        check_eq("idle_ready", {obs_s, bus.cmdReady}, 6'b000001);
        check_eq("idle_q", q_ds, 4'b0000);

        run_cmd("load1011", OP_LOAD, 4'b1011, 3'd0, 1, 4'b1011);
        run_cmd("shl2", OP_SHL, 4'b0000, 3'd2, 2, 4'b1100);
        check_eq("shl2_q", q_ds, 4'b1100);
        run_cmd("reload", OP_LOAD, 4'b1011, 3'd0, 1, 4'b1011);
        run_cmd("shr7", OP_SHR, 4'b0000, 3'd7, 7, 4'b0000);
        run_cmd("shr0", OP_SHR, 4'b1111, 3'd0, 0, 4'b0000);
        check_eq("d_held", bus.D, 4'b1011);
        run_cmd("load1001", OP_LOAD, 4'b1001, 3'd0, 1, 4'b1001);
        run_cmd("clear", OP_CLEAR, 4'b0110, 3'd5, 1, 4'b0000);
        check_eq("d_after_clear", bus.D, 4'b1001);

        // Second command held on cmdValid while a 3-step shift runs.
        run_cmd("load0101", OP_LOAD, 4'b0101, 3'd0, 1, 4'b0101);
        wait_ready("b2b");
        bus.cmdValid = 1'b1;
        bus.cmdOp    = OP_SHL;
        bus.cmdCount = 3'd3;
        @(negedge clk);
        bus.cmdOp    = OP_SHR;
        bus.cmdCount = 3'd1;
        for (int k = 0; k < 3; k++) begin
            check_eq("b2b_shl", {obs_s, bus.cmdReady}, 6'b001000);
            @(negedge clk);
        end
        check_eq("b2b_done1", {obs_s, bus.cmdReady}, 6'b100000);
        check_eq("b2b_res1", bus.result, 4'b1000);
        @(negedge clk);
        check_eq("b2b_ready", {obs_s, bus.cmdReady}, 6'b000001);
        @(negedge clk);
        check_eq("b2b_shr", {obs_s, bus.cmdReady}, 6'b010000);
        bus.cmdValid = 1'b0;
        @(negedge clk);
        check_eq("b2b_done2", obs_s, 5'b10000);
        check_eq("b2b_res2", bus.result, 4'b0100);
        @(negedge clk);
        check_eq("b2b_after", bus.cmdReady, 1'b1);

        // Reset cuts a 5-step shift after two strobes.
        run_cmd("load1111", OP_LOAD, 4'b1111, 3'd0, 1, 4'b1111);
        wait_ready("cut");
        bus.cmdValid = 1'b1;
        bus.cmdOp    = OP_SHL;
        bus.cmdCount = 3'd5;
        @(negedge clk);
        bus.cmdValid = 1'b0;
        check_eq("cut_shl1", obs_s, 5'b00100);
        @(negedge clk);
        check_eq("cut_shl2", obs_s, 5'b00100);
        resetN = 1'b0;
        #1;
        check_eq("cut_drop", {obs_s, bus.cmdReady, bus.busy}, 7'b0);
        check_eq("cut_data", {bus.D, bus.result}, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("cut_no_done", {obs_s, bus.cmdReady}, 6'b0);
        end
        resetN = 1'b1;
        @(negedge clk);
        check_eq("cut_init_clear", {obs_s, bus.cmdReady, bus.busy}, 7'b0000100);
        @(negedge clk);
        check_eq("cut_idle", {obs_s, bus.cmdReady}, 6'b000001);
        check_eq("cut_q", q_ds, 4'b0000);
        run_cmd("load0110", OP_LOAD, 4'b0110, 3'd0, 1, 4'b0110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
